sccb_cfg_master: RTL
====================

Name: sccb_cfg_master

Overview:
Parametrised successor to the camera-bring-up I2C writer. It walks an external register table and issues 3-phase SCCB/I2C writes to a configurable device address. The bus is true open-drain on both lines, and a quarter-bit timing engine drives it. Adds real ACK checking, per-entry retry, table-embedded delay and end markers, and optional clock stretching. Sits between the board-level start button/sequencer and the camera's SIOC/SIOD pins.

Parameters:
CLK_HZ, 100000000, system clock frequency
SCL_HZ, 400000, target SCL frequency; quarter-tick divider QDIV = CLK_HZ/(4*SCL_HZ), must be >= 2
DEV_ADDR, 7'h21, 7-bit slave address; write byte = {DEV_ADDR,1'b0} (0x42 default)
NUM_REGS, 76, table length; entries 0..NUM_REGS-1
IDX_W, 8, table index width; NUM_REGS <= 2**IDX_W
MAX_RETRY, 3, re-attempts per entry after NACK before fatal error
GAP_QTICKS, 28, idle quarter-ticks between STOP and the next START
DELAY_CYCLES, 1000000, clk cycles waited for a delay marker (10 ms @100 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle or level request; acted on only in IDLE
rom_addr  out  IDX_W  table index; rom_data valid one clk after rom_addr changes
rom_data  in  16  {reg_addr[15:8], reg_data[7:0]}; 16'hFFFF = end marker, 16'hFFF0 = delay marker
scl_i  in  1  sampled SCL pin (used only with CLK_STRETCH_EN)
scl_oe  out  1  1 = pull SCL low, 0 = release
sda_i  in  1  sampled SDA pin (2-flop synchronised internally)
sda_oe  out  1  1 = pull SDA low, 0 = release
busy  out  1  sequence in progress
done  out  1  sticky; sequence completed without fatal error
error  out  1  sticky; entry failed MAX_RETRY+1 times
err_index  out  IDX_W  index of the failing entry
nack_total  out  8  saturating count of NACKs seen this run

Behaviour:
- Reset: scl_oe=0, sda_oe=0 (bus released), busy=0, done=0, error=0, err_index=0, nack_total=0, rom_addr=0, state IDLE, divider cleared. An async reset mid-transfer releases both lines on the next edge. No STOP is generated.
- Quarter-tick qt pulses one clk every QDIV clk. It free-runs only while busy. Every bus action advances on qt.
- IDLE: both lines released. A start level seen while IDLE clears done/error/nack_total, sets rom_addr=0 and busy=1, and moves to FETCH. Start while busy is ignored.
- FETCH: wait 2 clk for the ROM. If rom_addr==NUM_REGS or the entry is 16'hFFFF, go to FINISH. If the entry is 16'hFFF0, go to DELAY. Otherwise latch the entry and go to START.
- START, 4 qt: SDA released with SCL released. Then SDA low while SCL is high. Then SCL low.
- BYTE: 3 bytes in order: address byte, reg_addr, reg_data. Per bit, 4 qt: q0 set SDA (MSB first, sda_oe = ~bit) with SCL low; q1 release SCL; q2 hold; q3 pull SCL low. SDA never changes while SCL is high.
- ACK, 9th bit: q0 release SDA; q1 release SCL; q2 sample synchronised SDA (0 = ACK); q3 SCL low.
- NACK on any byte: jump straight to STOP, nack_total+1 (saturating at 255), retry counter+1. After STOP and GAP, re-issue the same entry. When the retry counter exceeds MAX_RETRY: error=1, err_index=rom_addr, go to FINISH.
- ACK on byte 3: STOP, then GAP, then rom_addr+1, then FETCH. The retry counter resets per entry.
- STOP, 3 qt: SDA low with SCL low; SCL released; SDA released.
- GAP: GAP_QTICKS qt with the bus idle.
- DELAY: count DELAY_CYCLES clk, rom_addr+1, FETCH.
- FINISH: busy=0. done=1 only if error=0. Return to IDLE. done and error hold until the next accepted start.
- Latency of one clean entry: (4 + 27*4 + 3 + GAP_QTICKS) qt = 143 qt with defaults.

Optional Feature:
CLK_STRETCH_EN: when defined, after every SCL release the qt counter freezes until synchronised scl_i reads 1, so the slave can stretch the clock. When undefined, scl_i is ignored and timing is purely divider-driven.

Decomposition:
- sccb_pkg: state enum, marker constants CFG_END=16'hFFFF and CFG_DELAY=16'hFFF0, and the phase enum Q0..Q3.
- One sub-module, sccb_qtick_gen (divider plus stretch freeze), which outputs qt.
- The table ROM stays external, which lets the camera_config_ROM instance be reused.

Test Plan:
- Default parameters, 3-entry table {1280, 1100, FFFF}, slave model always ACKs. Required: bus bytes 42,12,80 then 42,11,00; done=1 after 2 transactions; SDA never toggles while SCL is high.
- Slave NACKs the reg_addr of entry 1 twice. Required: entry 1 sent 3 times; nack_total=2; done=1; error=0.
- Slave NACKs the device address always, MAX_RETRY=3. Required: 4 attempts on entry 0, error=1, err_index=0, done=0, busy=0.
- Table with a delay marker at index 1, DELAY_CYCLES=500. Required: at least 500 clk of idle bus between the entry-0 STOP and the entry-2 START.
- Async reset asserted mid-data-bit. Required: scl_oe=sda_oe=0 immediately; a new start restarts at rom_addr=0.
- With CLK_STRETCH_EN, the slave holds SCL low 300 clk on byte-2 ACK. Required: no qt advance until release, then correct completion.

Source files
------------

// File: rtl/sccb_pkg.sv
// sccb_pkg: FSM states, quarter-bit phases and table marker codes shared by the SCCB config master.
package sccb_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_BYTE   = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_DELAY  = 3'd6;
  localparam logic [2:0] S_FINISH = 3'd7;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFF0;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return v == 8'hFF ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/sccb_qtick_gen.sv
// sccb_qtick_gen: quarter-bit tick divider; with CLK_STRETCH_EN it freezes while a released SCL still reads low.
module sccb_qtick_gen #(
  parameter int QDIV = 62
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic scl_rel_i,
  input  logic scl_i,
  output logic qt_o
);
  localparam int CW = $clog2(QDIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic frz, wrap;
`ifdef CLK_STRETCH_EN
  logic [1:0] scl_s_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) scl_s_q <= 2'b11;
    else scl_s_q <= {scl_s_q[0], scl_i};
  assign frz = scl_rel_i & ~scl_s_q[1];
`else
  logic unused_scl;
  assign unused_scl = scl_i ^ scl_rel_i;
  assign frz = 1'b0;
`endif
  assign wrap  = cnt_q == CW'(QDIV - 1);
  assign cnt_d = !en_i ? '0 : frz ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
  assign qt_o  = en_i & ~frz & wrap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sccb_cfg_master.sv
// sccb_cfg_master: walks an external register table and issues 3-phase SCCB writes with ACK check and retry.
// Define CLK_STRETCH_EN to let the slave stretch SCL.
module sccb_cfg_master
  import sccb_pkg::*;
#(
  parameter int          CLK_HZ       = 100_000_000,
  parameter int          SCL_HZ       = 400_000,
  parameter logic [6:0]  DEV_ADDR     = 7'h21,
  parameter int          NUM_REGS     = 76,
  parameter int          IDX_W        = 8,
  parameter int          MAX_RETRY    = 3,
  parameter int          GAP_QTICKS   = 28,
  parameter int          DELAY_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [15:0]      rom_data,
  input  logic             scl_i,
  output logic             scl_oe,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index,
  output logic [7:0]       nack_total
);
  localparam int QDIV = CLK_HZ / (4 * SCL_HZ);
  localparam int RW   = $clog2(MAX_RETRY + 2);
  logic [2:0]       state_q, state_d;
  logic [1:0]       ph_q, ph_d, byte_q, byte_d, sda_s_q;
  logic [3:0]       bit_q, bit_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [15:0]      entry_q, entry_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [IDX_W-1:0] addr_q, addr_d, eidx_q, eidx_d, adv_addr;
  logic [7:0]       ntot_q, ntot_d, cur_byte;
  logic             nack_q, nack_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             scl_q, scl_d, sda_q, sda_d;
  logic             qt, ack_bit, tx_bit, last;
  logic [2:0]       adv_state;
  sccb_qtick_gen #(.QDIV(QDIV)) u_qtick (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (busy_q),
    .scl_rel_i (~scl_q),
    .scl_i     (scl_i),
    .qt_o      (qt)
  );
  assign cur_byte  = byte_q == 2'd0 ? {DEV_ADDR, 1'b0} : byte_q == 2'd1 ? entry_q[15:8] : entry_q[7:0];
  assign ack_bit   = bit_q == 4'd8;
  assign tx_bit    = cur_byte[~bit_q[2:0]];
  // Stepping past the last slot ends the run, so rom_addr never has to hold NUM_REGS.
  assign last      = addr_q == IDX_W'(NUM_REGS - 1);
  assign adv_state = last ? S_FINISH : S_FETCH;
  assign adv_addr  = last ? addr_q : addr_q + 1'b1;
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    entry_d = entry_q;
    retry_d = retry_q;
    nack_d  = nack_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    eidx_d  = eidx_q;
    ntot_d  = ntot_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    case (state_q)
      S_IDLE: begin
        scl_d = 1'b0;
        sda_d = 1'b0;
        if (start) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          ntot_d  = '0;
          addr_d  = '0;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      S_FETCH: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q != 32'd0) begin
          cnt_d   = '0;
          entry_d = rom_data;
          ph_d    = Q0;
          bit_d   = '0;
          byte_d  = '0;
          state_d = rom_data == CFG_END ? S_FINISH : rom_data == CFG_DELAY ? S_DELAY : S_START;
        end
      end
      S_START: if (qt) begin
        ph_d    = ph_q + 2'd1;
        sda_d   = ph_q != Q0;
        scl_d   = ph_q == Q3;
        state_d = ph_q == Q3 ? S_BYTE : S_START;
      end
      S_BYTE: if (qt) begin
        ph_d   = ph_q + 2'd1;
        sda_d  = ph_q == Q0 ? ~ack_bit & ~tx_bit : sda_q;
        scl_d  = ph_q == Q1 ? 1'b0 : ph_q == Q3 ? 1'b1 : scl_q;
        nack_d = ph_q == Q2 && ack_bit ? sda_s_q[1] : nack_q;
        if (ph_q == Q3) begin
          bit_d  = ack_bit ? 4'd0 : bit_q + 4'd1;
          byte_d = ack_bit ? byte_q + 2'd1 : byte_q;
          if (ack_bit && (nack_q || byte_q == 2'd2)) state_d = S_STOP;
          if (ack_bit && nack_q) begin
            ntot_d  = sat_inc8(ntot_q);
            retry_d = retry_q + 1'b1;
          end
        end
      end
      S_STOP: if (qt) begin
        ph_d  = ph_q == Q2 ? Q0 : ph_q + 2'd1;
        sda_d = ph_q != Q2;
        scl_d = ph_q == Q0;
        if (ph_q == Q2) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: if (qt) begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q + 32'd1 >= 32'(GAP_QTICKS)) begin
          cnt_d = '0;
          if (nack_q && retry_q > RW'(MAX_RETRY)) begin
            err_d   = 1'b1;
            eidx_d  = addr_q;
            state_d = S_FINISH;
          end else if (nack_q) begin
            state_d = S_START;
            bit_d   = '0;
            byte_d  = '0;
          end else begin
            state_d = adv_state;
            addr_d  = adv_addr;
            retry_d = '0;
          end
        end
      end
      S_DELAY: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q + 32'd1 >= 32'(DELAY_CYCLES)) begin
          cnt_d   = '0;
          state_d = adv_state;
          addr_d  = adv_addr;
          retry_d = '0;
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = ~err_q;
        scl_d   = 1'b0;
        sda_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= Q0;
      bit_q   <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
      entry_q <= '0;
      retry_q <= '0;
      nack_q  <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
      ntot_q  <= '0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
      sda_s_q <= 2'b11;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      retry_q <= retry_d;
      nack_q  <= nack_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      eidx_q  <= eidx_d;
      ntot_q  <= ntot_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      sda_s_q <= {sda_s_q[0], sda_i};
    end
  assign rom_addr   = addr_q;
  assign scl_oe     = scl_q;
  assign sda_oe     = sda_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign err_index  = eidx_q;
  assign nack_total = ntot_q;
endmodule
